if_rd_sequencer: RTL and testbench

- Single-clock, multi-channel successor of the chip-side SPI read-transfer controller.
- Arbitrates configuration-read requests from NUM_CH on-chip consumers and drives the config_req/config-word handshake to the FPGA.
- Waits for the synchronised chip-select, pulls exactly the programmed number of words from the external async-FIFO read port, then routes them to the owning channel.
- Adds three things the previous generation lacked: a runtime-programmable size table, an over-read guard, and a WAIT timeout.

---
 rtl/if_rd_pkg.sv | 29 ++
 rtl/if_rd_sequencer_rr_arbiter.sv | 31 +++
 rtl/if_rd_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_if_rd_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_rd_pkg.sv
// Shared definitions for the interface read sequencer: FSM encoding,
// transfer-type codes and cfg_word field placement.
package if_rd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONFIG,
    ST_WAIT,
    ST_RD_DATA,
    ST_DONE
  } state_e;

  // Transfer-type codes understood by the FPGA side.
  localparam int CODE_CFG    = 0;
  localparam int CODE_ACT    = 1;
  localparam int CODE_FLGACT = 2;
  localparam int CODE_WEI    = 3;
  localparam int CODE_FLGWEI = 4;

  // cfg_word is {code, sched, zeros}, code left-aligned in the word.
  function automatic int cfg_code_lsb(input int data_w, input int code_w);
    return data_w - code_w;
  endfunction

  function automatic int cfg_sched_lsb(input int data_w, input int code_w, input int sched_w);
    return data_w - code_w - sched_w;
  endfunction

endpackage

// File: rtl/if_rd_sequencer_rr_arbiter.sv
// Round-robin arbiter: first active request at or after ptr wins.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [PTR_W-1:0]  gnt_idx
);

  int   idx;
  logic found;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(ptr) + i) % NUM_CH;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/if_rd_sequencer.sv
// Multi-channel config-read sequencer: arbitrates channel requests, issues
// config_req/cfg_word to the FPGA, then pulls exactly size words from the FIFO.
module if_rd_sequencer
  import if_rd_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int CODE_WIDTH  = 4,
  parameter int SCHED_WIDTH = 8,
  parameter int CNT_WIDTH   = 20,
  parameter int SIZE_RST    = 2048,
  parameter int TO_WIDTH    = 16
) (
  input  logic                          clk_chip,
  input  logic                          reset_n_chip,
  input  logic [NUM_CH-1:0]             req_valid,
  input  logic [NUM_CH*CODE_WIDTH-1:0]  req_code,
  input  logic [NUM_CH*SCHED_WIDTH-1:0] req_sched,
  output logic [NUM_CH-1:0]             req_ready,
  input  logic                          size_wr_en,
  input  logic [CODE_WIDTH-1:0]         size_wr_code,
  input  logic [CNT_WIDTH-1:0]          size_wr_data,
  output logic                          config_req,
  output logic [DATA_WIDTH-1:0]         cfg_word,
  input  logic                          spi_cs_n,
  input  logic                          fifo_empty,
  output logic                          fifo_rd_en,
  input  logic                          fifo_valid,
  input  logic [DATA_WIDTH-1:0]         fifo_dout,
  input  logic [NUM_CH-1:0]             ch_rd_req,
  output logic [NUM_CH-1:0]             ch_valid,
  output logic [DATA_WIDTH-1:0]         ch_data,
  output logic [NUM_CH-1:0]             ch_done,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int PTR_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TBL_DEPTH = 2 ** CODE_WIDTH;
  localparam int CODE_LSB  = cfg_code_lsb(DATA_WIDTH, CODE_WIDTH);
  localparam int SCHED_LSB = cfg_sched_lsb(DATA_WIDTH, CODE_WIDTH, SCHED_WIDTH);

  state_e                  state_q, state_d;
  logic [PTR_W-1:0]        owner_q, owner_d, rr_ptr_q, rr_ptr_d;
  logic [CODE_WIDTH-1:0]   code_q, code_d;
  logic [SCHED_WIDTH-1:0]  sched_q, sched_d;
  logic [CNT_WIDTH-1:0]    size_q, size_d, issued_q, issued_d, rcvd_q, rcvd_d;
  logic [TO_WIDTH-1:0]     to_cnt_q, to_cnt_d, to_inc;
  logic                    config_req_q, config_req_d;
  logic [DATA_WIDTH-1:0]   cfg_word_q, cfg_word_d;
  logic [NUM_CH-1:0]       req_ready_q, req_ready_d, ch_done_q, ch_done_d;
  logic                    timeout_err_q, timeout_err_d;
  logic [2:0]              cs_sync_q, cs_sync_d;
  logic [CNT_WIDTH-1:0]    size_tbl_q [TBL_DEPTH];
  logic [CNT_WIDTH-1:0]    size_tbl_d [TBL_DEPTH];

  logic [NUM_CH-1:0]       gnt;
  logic [PTR_W-1:0]        gnt_idx;
  logic [CODE_WIDTH-1:0]   gnt_code;
  logic [SCHED_WIDTH-1:0]  gnt_sched;
  logic                    cs_sync;

  rr_arbiter #(.NUM_CH(NUM_CH), .PTR_W(PTR_W)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign gnt_code  = req_code[gnt_idx*CODE_WIDTH +: CODE_WIDTH];
  assign gnt_sched = req_sched[gnt_idx*SCHED_WIDTH +: SCHED_WIDTH];
  assign cs_sync   = cs_sync_q[2];
  assign to_inc    = to_cnt_q + 1'b1;
  assign cs_sync_d = {cs_sync_q[1:0], spi_cs_n};

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    code_d        = code_q;
    sched_d       = sched_q;
    size_d        = size_q;
    issued_d      = issued_q;
    rcvd_d        = rcvd_q;
    to_cnt_d      = to_cnt_q;
    rr_ptr_d      = rr_ptr_q;
    config_req_d  = config_req_q;
    cfg_word_d    = cfg_word_q;
    req_ready_d   = '0;
    ch_done_d     = '0;
    timeout_err_d = 1'b0;
    fifo_rd_en    = 1'b0;
    ch_valid      = '0;

    // The grant below reads size_tbl_q, so a same-cycle write is seen only by later grants.
    size_tbl_d = size_tbl_q;
    if (size_wr_en) size_tbl_d[size_wr_code] = size_wr_data;

    unique case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          req_ready_d = gnt;
          owner_d     = gnt_idx;
          code_d      = gnt_code;
          sched_d     = gnt_sched;
          size_d      = size_tbl_q[gnt_code];
          if (size_tbl_q[gnt_code] == '0) begin
            ch_done_d = gnt;
            state_d   = ST_DONE;
          end else begin
            state_d = ST_CONFIG;
          end
        end
      end
      ST_CONFIG: begin
        config_req_d                           = 1'b1;
        cfg_word_d                             = '0;
        cfg_word_d[CODE_LSB +: CODE_WIDTH]     = code_q;
        cfg_word_d[SCHED_LSB +: SCHED_WIDTH]   = sched_q;
        to_cnt_d                               = '0;
        state_d                                = ST_WAIT;
      end
      ST_WAIT: begin
        if (!cs_sync) begin
          config_req_d = 1'b0;
          state_d      = ST_RD_DATA;
        end else if (&to_inc) begin
          timeout_err_d      = 1'b1;
          config_req_d       = 1'b0;
          ch_done_d[owner_q] = 1'b1;
          state_d            = ST_DONE;
        end else begin
          to_cnt_d = to_inc;
        end
      end
      ST_RD_DATA: begin
        config_req_d = 1'b0;
        fifo_rd_en   = !fifo_empty && ch_rd_req[owner_q] && (issued_q < size_q);
        if (fifo_rd_en) issued_d = issued_q + 1'b1;
        if (fifo_valid) rcvd_d = rcvd_q + 1'b1;
        ch_valid[owner_q] = fifo_valid;
        if (rcvd_q == size_q) begin
          ch_done_d[owner_q] = 1'b1;
          state_d            = ST_DONE;
        end
      end
      ST_DONE: begin
        issued_d = '0;
        rcvd_d   = '0;
        rr_ptr_d = (owner_q == PTR_W'(NUM_CH - 1)) ? '0 : owner_q + 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_chip or negedge reset_n_chip) begin
    if (!reset_n_chip) begin
      state_q       <= ST_IDLE;
      owner_q       <= '0;
      rr_ptr_q      <= '0;
      code_q        <= '0;
      sched_q       <= '0;
      size_q        <= '0;
      issued_q      <= '0;
      rcvd_q        <= '0;
      to_cnt_q      <= '0;
      config_req_q  <= 1'b0;
      cfg_word_q    <= '0;
      req_ready_q   <= '0;
      ch_done_q     <= '0;
      timeout_err_q <= 1'b0;
      cs_sync_q     <= 3'b111;
      // NOTE: the size table is a register array with a reset value, not a RAM; reset restores it.
      for (int i = 0; i < TBL_DEPTH; i++) size_tbl_q[i] <= CNT_WIDTH'(SIZE_RST);
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      code_q        <= code_d;
      sched_q       <= sched_d;
      size_q        <= size_d;
      issued_q      <= issued_d;
      rcvd_q        <= rcvd_d;
      to_cnt_q      <= to_cnt_d;
      config_req_q  <= config_req_d;
      cfg_word_q    <= cfg_word_d;
      req_ready_q   <= req_ready_d;
      ch_done_q     <= ch_done_d;
      timeout_err_q <= timeout_err_d;
      cs_sync_q     <= cs_sync_d;
      size_tbl_q    <= size_tbl_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign config_req  = config_req_q;
  assign cfg_word    = cfg_word_q;
  assign ch_done     = ch_done_q;
  assign timeout_err = timeout_err_q;
  assign ch_data     = fifo_dout;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_if_rd_sequencer.sv
// Scoreboard bench for if_rd_sequencer with FIFO and FPGA chip-select models.
module tb_if_rd_sequencer;
  import if_rd_pkg::*;

  localparam int NCH = 4;

  logic          clk_chip = 1'b0;
  logic          reset_n_chip;
  logic [3:0]    req_valid;
  logic [15:0]   req_code;
  logic [31:0]   req_sched;
  logic [3:0]    req_ready;
  logic          size_wr_en;
  logic [3:0]    size_wr_code;
  logic [19:0]   size_wr_data;
  logic          config_req;
  logic [31:0]   cfg_word;
  logic          spi_cs_n = 1'b1;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd_en;
  logic          fifo_valid = 1'b0;
  logic [31:0]   fifo_dout = '0;
  logic [3:0]    ch_rd_req;
  logic [3:0]    ch_valid;
  logic [31:0]   ch_data;
  logic [3:0]    ch_done;
  logic          busy;
  logic          timeout_err;

  if_rd_sequencer #(
    .NUM_CH(NCH), .DATA_WIDTH(32), .CODE_WIDTH(4), .SCHED_WIDTH(8),
    .CNT_WIDTH(20), .SIZE_RST(6), .TO_WIDTH(4)
  ) dut (
    .clk_chip(clk_chip), .reset_n_chip(reset_n_chip),
    .req_valid(req_valid), .req_code(req_code), .req_sched(req_sched), .req_ready(req_ready),
    .size_wr_en(size_wr_en), .size_wr_code(size_wr_code), .size_wr_data(size_wr_data),
    .config_req(config_req), .cfg_word(cfg_word), .spi_cs_n(spi_cs_n),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_valid(fifo_valid), .fifo_dout(fifo_dout),
    .ch_rd_req(ch_rd_req), .ch_valid(ch_valid), .ch_data(ch_data), .ch_done(ch_done),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk_chip = ~clk_chip;

  typedef struct {
    int          ch;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          done_q[$];
  logic [31:0] fifo_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int pop_cnt = 0;
  int rx_cnt = 0;
  int cfg_hi_cnt = 0;
  bit fpga_en = 1'b1;
  bit exp_to = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // External async-FIFO read port: data valid one cycle after the pop.
  always @(posedge clk_chip) begin
    if (fifo_rd_en && fifo_q.size() != 0) begin
      fifo_dout  <= fifo_q.pop_front();
      fifo_valid <= 1'b1;
      pop_cnt++;
    end else begin
      fifo_valid <= 1'b0;
    end
    fifo_empty <= (fifo_q.size() == 0);
  end

  // FPGA answers an asserted config_req by pulling chip-select low.
  always @(negedge clk_chip) spi_cs_n = fpga_en ? !config_req : 1'b1;

  // Output monitor: pops the scoreboard whenever the DUT delivers something.
  always @(negedge clk_chip) begin
    if (reset_n_chip) begin
      if (config_req) cfg_hi_cnt++;
      if (ch_valid != '0) begin
        rx_cnt++;
        if (exp_q.size() == 0) check("unexp_valid", ch_valid, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check("valid_ch", ch_valid, 64'(1) << e.ch);
          check("data", ch_data, e.data);
        end
      end
      if (ch_done != '0) begin
        if (done_q.size() == 0) check("unexp_done", ch_done, 0);
        else check("done_ch", ch_done, 64'(1) << done_q.pop_front());
      end
      if (timeout_err) check("unexp_timeout", timeout_err, exp_to);
    end
  end

  task automatic set_req(input int ch, input int code, input int sched);
    req_valid[ch]           = 1'b1;
    req_code[ch*4 +: 4]     = 4'(code);
    req_sched[ch*8 +: 8]    = 8'(sched);
  endtask

  task automatic wait_grant(input string tag, input logic [3:0] exp_g);
    logic [3:0] g;
    g = '0;
    for (int i = 0; i < 50 && g == '0; i++) begin
      @(negedge clk_chip);
      g = req_ready;
    end
    check(tag, g, exp_g);
    req_valid = req_valid & ~g;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 3000 && done_q.size() != 0; i++) @(negedge clk_chip);
    check({tag, "_done_left"}, done_q.size(), 0);
    check({tag, "_words_left"}, exp_q.size(), 0);
  endtask

  task automatic wait_rx(input int base, input int n);
    for (int i = 0; i < 200 && (rx_cnt - base) < n; i++) @(negedge clk_chip);
  endtask

  task automatic write_size(input int code, input int val);
    size_wr_en   = 1'b1;
    size_wr_code = 4'(code);
    size_wr_data = 20'(val);
    @(negedge clk_chip);
    size_wr_en   = 1'b0;
  endtask

  task automatic preload(input int ch, input int n_exp, input int n_total);
    logic [31:0] w;
    for (int i = 0; i < n_total; i++) begin
      w = $urandom;
      fifo_q.push_back(w);
      if (i < n_exp) exp_q.push_back('{ch, w});
    end
    @(negedge clk_chip);
  endtask

  task automatic apply_reset();
    reset_n_chip = 1'b0;
    repeat (3) @(negedge clk_chip);
    reset_n_chip = 1'b1;
    @(negedge clk_chip);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_pop, base_rx, base_cfg, cnt;
    reset_n_chip = 1'b0;
    req_valid    = '0;
    req_code     = '0;
    req_sched    = '0;
    size_wr_en   = 1'b0;
    size_wr_code = '0;
    size_wr_data = '0;
    ch_rd_req    = 4'hF;
    #1;
    check("rst_config_req", config_req, 0);
    check("rst_cfg_word", cfg_word, 0);
    check("rst_busy", busy, 0);
    check("rst_pulses", {req_ready, ch_done, ch_valid, timeout_err, fifo_rd_en}, 0);
    repeat (2) @(negedge clk_chip);
    reset_n_chip = 1'b1;
    @(negedge clk_chip);

    // Basic read: 5 of 8 preloaded words go to ch1.
    write_size(CODE_FLGACT, 5);
    preload(1, 5, 8);
    done_q.push_back(1);
    base_pop = pop_cnt;
    set_req(1, CODE_FLGACT, 8'h3C);
    wait_grant("t1_grant", 4'b0010);
    for (int i = 0; i < 20 && !config_req; i++) @(negedge clk_chip);
    check("t1_config_req", config_req, 1);
    check("t1_cfg_word", cfg_word, 32'h23C0_0000);
    wait_done("t1");
    check("t1_pops", pop_cnt - base_pop, 5);
    check("t1_fifo_left", fifo_q.size(), 3);
    fifo_q.delete();
    repeat (3) @(negedge clk_chip);

    // Round robin from rr_ptr=0: ch0, then ch2 (ch1 idle), then ch0 again.
    apply_reset();
    write_size(CODE_ACT, 2);
    preload(0, 2, 2);
    preload(2, 2, 2);
    preload(0, 2, 2);
    done_q.push_back(0);
    done_q.push_back(2);
    done_q.push_back(0);
    set_req(0, CODE_ACT, 8'h01);
    set_req(2, CODE_ACT, 8'h02);
    wait_grant("rr_first", 4'b0001);
    @(negedge clk_chip);
    set_req(0, CODE_ACT, 8'h03);
    wait_grant("rr_second", 4'b0100);
    wait_grant("rr_third", 4'b0001);
    wait_done("rr");
    repeat (3) @(negedge clk_chip);

    // Consumer back-pressure: no pops while ch_rd_req[owner] is low.
    write_size(CODE_FLGWEI, 8);
    preload(0, 8, 8);
    done_q.push_back(0);
    base_pop = pop_cnt;
    base_rx  = rx_cnt;
    set_req(0, CODE_FLGWEI, 8'h5A);
    wait_grant("stall_grant", 4'b0001);
    wait_rx(base_rx, 2);
    check("stall_started", (rx_cnt - base_rx) >= 2, 1);
    ch_rd_req[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_chip);
      check("stall_rd_en", fifo_rd_en, 0);
    end
    ch_rd_req[0] = 1'b1;
    wait_done("stall");
    check("stall_pops", pop_cnt - base_pop, 8);
    check("stall_rx", rx_cnt - base_rx, 8);
    repeat (3) @(negedge clk_chip);

    // WAIT timeout: chip-select never falls.
    fpga_en  = 1'b0;
    exp_to   = 1'b1;
    base_pop = pop_cnt;
    done_q.push_back(3);
    set_req(3, CODE_ACT, 8'h77);
    wait_grant("to_grant", 4'b1000);
    for (int i = 0; i < 20 && !config_req; i++) @(negedge clk_chip);
    cnt = config_req ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_chip);
      if (timeout_err) break;
      if (config_req) cnt++;
    end
    check("to_pulse", timeout_err, 1);
    check("to_wait_cycles", cnt, 15);
    check("to_cfg_low", config_req, 0);
    @(negedge clk_chip);
    check("to_idle", busy, 0);
    check("to_pulse_len", timeout_err, 0);
    wait_done("to");
    check("to_pops", pop_cnt - base_pop, 0);
    exp_to  = 1'b0;
    fpga_en = 1'b1;
    repeat (3) @(negedge clk_chip);

    // Size write collides with the grant of the same code: old size is used.
    preload(0, 6, 6);
    done_q.push_back(0);
    base_pop     = pop_cnt;
    set_req(0, CODE_WEI, 8'h11);
    size_wr_en   = 1'b1;
    size_wr_code = 4'(CODE_WEI);
    size_wr_data = '0;
    wait_grant("coll_grant", 4'b0001);
    size_wr_en   = 1'b0;
    wait_done("coll");
    check("coll_pops", pop_cnt - base_pop, 6);
    repeat (3) @(negedge clk_chip);

    // Size 0 now: immediate completion, no config_req, no pops.
    done_q.push_back(0);
    base_pop = pop_cnt;
    base_cfg = cfg_hi_cnt;
    set_req(0, CODE_WEI, 8'h12);
    wait_grant("zero_grant", 4'b0001);
    wait_done("zero");
    repeat (3) @(negedge clk_chip);
    check("zero_cfg_req", cfg_hi_cnt - base_cfg, 0);
    check("zero_pops", pop_cnt - base_pop, 0);

    // Reset in the middle of RD_DATA.
    write_size(5, 10);
    preload(1, 10, 10);
    done_q.push_back(1);
    base_rx = rx_cnt;
    set_req(1, 5, 8'h44);
    wait_grant("mid_grant", 4'b0010);
    wait_rx(base_rx, 3);
    check("mid_in_transfer", busy, 1);
    #2 reset_n_chip = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_config_req", config_req, 0);
    check("mid_rst_cfg_word", cfg_word, 0);
    check("mid_rst_pulses", {req_ready, ch_done, ch_valid, timeout_err, fifo_rd_en}, 0);
    exp_q.delete();
    done_q.delete();
    fifo_q.delete();
    repeat (2) @(negedge clk_chip);
    reset_n_chip = 1'b1;
    @(negedge clk_chip);

    // Code 3 was zeroed earlier; reset must have restored SIZE_RST (6).
    preload(1, 6, 6);
    done_q.push_back(1);
    base_pop = pop_cnt;
    set_req(1, CODE_WEI, 8'h21);
    wait_grant("post_rst_grant", 4'b0010);
    wait_done("post_rst");
    check("post_rst_pops", pop_cnt - base_pop, 6);
    repeat (3) @(negedge clk_chip);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
